// File: rtl/vjtag_counter_ctrl.sv
// vjtag_counter_ctrl: virtual-JTAG controlled WIDTH-bit counter with read/inc/dec/clear/load/status.
// Optional build macro VJTAG_CNT_SATURATE_EN: INC/DEC saturate at the rails instead of wrapping.
module vjtag_counter_ctrl #(
    parameter int WIDTH    = 8,
    parameter int IR_WIDTH = 3
) (
    input  logic                tck,
    input  logic                aclr,
    input  logic                tdi,
    input  logic [IR_WIDTH-1:0] ir_in,
    input  logic                v_cdr,
    input  logic                v_sdr,
    input  logic                v_udr,
    input  logic                v_uir,
    output logic                tdo,
    output logic [WIDTH-1:0]    count,
    output logic                ovf
);
    typedef enum logic [2:0] {
        I_BYP0   = 3'b000,
        I_READ   = 3'b001,
        I_INC    = 3'b010,
        I_CLEAR  = 3'b011,
        I_LOAD   = 3'b100,
        I_STATUS = 3'b101,
        I_DEC    = 3'b110,
        I_BYP7   = 3'b111
    } instr_t;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    logic [WIDTH-1:0] cnt_q, cnt_d, dr_q, dr_d, cnt_inc, cnt_dec;
    logic             byp_q, byp_d, ovf_q, ovf_d;
    logic             legal, is_byp, at_max, at_min;
    instr_t           instr;
    // Any set bit above the 3-bit opcode field forces BYPASS.
    assign legal  = (ir_in >> 3) == '0;
    assign instr  = legal ? instr_t'(ir_in[2:0]) : I_BYP0;
    assign is_byp = (instr == I_BYP0) || (instr == I_BYP7);
    assign at_max = &cnt_q;
    assign at_min = ~|cnt_q;
`ifdef VJTAG_CNT_SATURATE_EN
    assign cnt_inc = at_max ? cnt_q : cnt_q + ONE;
    assign cnt_dec = at_min ? cnt_q : cnt_q - ONE;
`else
    assign cnt_inc = cnt_q + ONE;
    assign cnt_dec = cnt_q - ONE;
`endif
    assign tdo   = is_byp ? byp_q : dr_q[0];
    assign count = cnt_q;
    assign ovf   = ovf_q;
    // Next state: one strobe acts per cycle, uir > cdr > sdr > udr.
    always_comb begin
        cnt_d = cnt_q;
        dr_d  = dr_q;
        byp_d = byp_q;
        ovf_d = ovf_q;
        if (v_uir) begin
            dr_d  = '0;
            byp_d = 1'b0;
        end else if (v_cdr) begin
            case (instr)
                I_READ, I_LOAD: dr_d = cnt_q;
                I_INC: begin
                    cnt_d = cnt_inc;
                    dr_d  = cnt_inc;
                    ovf_d = ovf_q | at_max;
                end
                I_DEC: begin
                    cnt_d = cnt_dec;
                    dr_d  = cnt_dec;
                    ovf_d = ovf_q | at_min;
                end
                I_CLEAR: begin
                    cnt_d = '0;
                    dr_d  = '0;
                    ovf_d = 1'b0;
                end
                I_STATUS: dr_d = {{(WIDTH-1){1'b0}}, ovf_q};
                default: ;
            endcase
        end else if (v_sdr) begin
            byp_d = is_byp ? tdi : byp_q;
            dr_d  = is_byp ? dr_q : {tdi, dr_q[WIDTH-1:1]};
        end else if (v_udr) begin
            cnt_d = (instr == I_LOAD) ? dr_q : cnt_q;
            ovf_d = (instr == I_STATUS && dr_q[0]) ? 1'b0 : ovf_q;
        end
    end
    // State registers with synchronous reset.
    always_ff @(posedge tck) begin
        if (aclr) begin
            cnt_q <= '0;
            dr_q  <= '0;
            byp_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            dr_q  <= dr_d;
            byp_q <= byp_d;
            ovf_q <= ovf_d;
        end
    end
endmodule

// File: tb/tb_vjtag_counter_ctrl.sv
// tb_vjtag_counter_ctrl: randomized scans against an arithmetic counter model.
module tb_vjtag_counter_ctrl;
    localparam int W = 8;
    localparam int IRW = 4;
    localparam int MAXV = (1 << W) - 1;
`ifdef VJTAG_CNT_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    localparam logic [IRW-1:0] OP_BYP = 4'd0, OP_READ = 4'd1, OP_INC = 4'd2, OP_CLEAR = 4'd3;
    localparam logic [IRW-1:0] OP_LOAD = 4'd4, OP_STATUS = 4'd5, OP_DEC = 4'd6, OP_BYP7 = 4'd7;
    logic tck = 0, aclr = 0, tdi = 0, v_cdr = 0, v_sdr = 0, v_udr = 0, v_uir = 0;
    logic [IRW-1:0] ir_in = '0;
    logic tdo, ovf;
    logic [W-1:0] count;
    int n_vec = 0, n_err = 0;
    int m_cnt = 0;
    bit m_ovf = 0;

    vjtag_counter_ctrl #(.WIDTH(W), .IR_WIDTH(IRW)) dut (
        .tck(tck), .aclr(aclr), .tdi(tdi), .ir_in(ir_in), .v_cdr(v_cdr), .v_sdr(v_sdr),
        .v_udr(v_udr), .v_uir(v_uir), .tdo(tdo), .count(count), .ovf(ovf)
    );

    always #5 tck = ~tck;

    task automatic tick();
        @(posedge tck);
        #1;
    endtask
    task automatic set_ir(input logic [IRW-1:0] op);
        ir_in = op;
        v_uir = 1;
        tick();
        v_uir = 0;
    endtask
    task automatic capture(input int n);
        v_cdr = 1;
        repeat (n) tick();
        v_cdr = 0;
    endtask
    task automatic scan(input logic [W-1:0] din, output logic [W-1:0] dout);
        for (int i = 0; i < W; i++) begin
            dout[i] = tdo;
            tdi = din[i];
            v_sdr = 1;
            tick();
        end
        v_sdr = 0;
        tdi = 0;
    endtask
    task automatic update();
        v_udr = 1;
        tick();
        v_udr = 0;
    endtask
    task automatic do_load(input logic [W-1:0] v);
        logic [W-1:0] junk;
        set_ir(OP_LOAD);
        capture(1);
        scan(v, junk);
        update();
        m_cnt = int'(v);
    endtask
    function automatic void m_inc();
        if (m_cnt == MAXV) begin
            m_ovf = 1;
            m_cnt = SAT ? MAXV : 0;
        end else m_cnt++;
    endfunction
    function automatic void m_dec();
        if (m_cnt == 0) begin
            m_ovf = 1;
            m_cnt = SAT ? 0 : MAXV;
        end else m_cnt--;
    endfunction

    task automatic test_reset();
        logic [W-1:0] d;
        aclr = 1;
        tick();
        aclr = 0;
        m_cnt = 0;
        m_ovf = 0;
        n_vec += 3;
        if (count !== 8'h00) begin n_err++; $display("FAIL reset_count got %h want 00", count); end
        if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b want 0", ovf); end
        if (tdo !== 1'b0) begin n_err++; $display("FAIL reset_tdo got %b want 0", tdo); end
        set_ir(OP_READ);
        capture(1);
        scan(8'h00, d);
        n_vec += 3;
        if (d !== 8'h00) begin n_err++; $display("FAIL reset_read got %h want 00", d); end
        if (count !== 8'h00) begin n_err++; $display("FAIL reset_read_count got %h want 00", count); end
        if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_read_ovf got %b want 0", ovf); end
    endtask

    task automatic test_load_read();
        logic [W-1:0] vals[8];
        logic [W-1:0] old, d;
        int prev;
        vals[0] = 8'hA5; vals[1] = 8'h00; vals[2] = 8'hFF;
        for (int i = 3; i < 8; i++) vals[i] = W'($urandom);
        foreach (vals[i]) begin
            prev = m_cnt;
            set_ir(OP_LOAD);
            capture(1);
            scan(vals[i], old);
            update();
            m_cnt = int'(vals[i]);
            n_vec += 2;
            if (old !== W'(prev)) begin n_err++; $display("FAIL load_capture got %h want %h", old, W'(prev)); end
            if (count !== W'(m_cnt)) begin n_err++; $display("FAIL load_count got %h want %h", count, W'(m_cnt)); end
            set_ir(OP_READ);
            capture(1);
            scan(W'($urandom), d);
            update();
            n_vec += 2;
            if (d !== vals[i]) begin n_err++; $display("FAIL read_scan got %h want %h", d, vals[i]); end
            if (count !== vals[i]) begin n_err++; $display("FAIL read_count got %h want %h", count, vals[i]); end
        end
    endtask

    task automatic test_inc_dec_random();
        logic [W-1:0] d;
        logic [W-1:0] picks[5];
        int r, n;
        picks[0] = 8'h00; picks[1] = 8'h01; picks[2] = 8'hFE; picks[3] = 8'hFF;
        for (int it = 0; it < 60; it++) begin
            r = $urandom_range(0, 9);
            picks[4] = W'($urandom);
            if (r < 2) begin
                do_load(picks[$urandom_range(0, 4)]);
                continue;
            end
            n = $urandom_range(1, 3);
            if (r < 5) begin
                set_ir(OP_INC);
                capture(n);
                repeat (n) m_inc();
            end else if (r < 8) begin
                set_ir(OP_DEC);
                capture(n);
                repeat (n) m_dec();
            end else if (r == 8) begin
                set_ir(OP_CLEAR);
                capture(n);
                m_cnt = 0;
                m_ovf = 0;
            end else begin
                set_ir(OP_READ);
                capture(n);
            end
            n_vec += 3;
            if (count !== W'(m_cnt)) begin n_err++; $display("FAIL step_count got %h want %h", count, W'(m_cnt)); end
            if (ovf !== m_ovf) begin n_err++; $display("FAIL step_ovf got %b want %b", ovf, m_ovf); end
            scan(W'($urandom), d);
            update();
            if (d !== W'(m_cnt)) begin n_err++; $display("FAIL step_capture got %h want %h", d, W'(m_cnt)); end
        end
    endtask

    task automatic test_boundary();
        logic [W-1:0] d;
        set_ir(OP_CLEAR);
        capture(1);
        m_cnt = 0;
        m_ovf = 0;
        do_load(8'hFF);
        set_ir(OP_INC);
        capture(1);
        n_vec += 2;
        if (count !== (SAT ? 8'hFF : 8'h00)) begin n_err++; $display("FAIL inc_edge_count got %h want %h", count, SAT ? 8'hFF : 8'h00); end
        if (ovf !== 1'b1) begin n_err++; $display("FAIL inc_edge_ovf got %b want 1", ovf); end
        set_ir(OP_STATUS);
        capture(1);
        scan(8'hFE, d);
        update();
        n_vec += 2;
        if (d !== 8'h01) begin n_err++; $display("FAIL status_read got %h want 01", d); end
        if (ovf !== 1'b1) begin n_err++; $display("FAIL status_w0_ovf got %b want 1", ovf); end
        set_ir(OP_STATUS);
        capture(1);
        scan(8'h01, d);
        update();
        n_vec += 1;
        if (ovf !== 1'b0) begin n_err++; $display("FAIL status_w1_ovf got %b want 0", ovf); end
        set_ir(OP_STATUS);
        capture(1);
        scan(8'h00, d);
        n_vec += 1;
        if (d !== 8'h00) begin n_err++; $display("FAIL status_clear_read got %h want 00", d); end
        do_load(8'h00);
        set_ir(OP_DEC);
        capture(1);
        n_vec += 2;
        if (count !== (SAT ? 8'h00 : 8'hFF)) begin n_err++; $display("FAIL dec_edge_count got %h want %h", count, SAT ? 8'h00 : 8'hFF); end
        if (ovf !== 1'b1) begin n_err++; $display("FAIL dec_edge_ovf got %b want 1", ovf); end
        set_ir(OP_CLEAR);
        capture(1);
        n_vec += 2;
        if (count !== 8'h00) begin n_err++; $display("FAIL clear_count got %h want 00", count); end
        if (ovf !== 1'b0) begin n_err++; $display("FAIL clear_ovf got %b want 0", ovf); end
        m_cnt = 0;
        m_ovf = 0;
    endtask

    task automatic test_bypass();
        logic [3:0] pat, got;
        logic [W-1:0] v;
        v = W'($urandom);
        do_load(v);
        pat = 4'b1101;
        set_ir(OP_BYP);
        for (int i = 0; i < 4; i++) begin
            got[i] = tdo;
            tdi = pat[i];
            v_sdr = 1;
            tick();
        end
        v_sdr = 0;
        tdi = 0;
        n_vec += 2;
        if (got !== 4'b1010) begin n_err++; $display("FAIL bypass_seq got %b want 1010", got); end
        if (tdo !== 1'b1) begin n_err++; $display("FAIL bypass_last got %b want 1", tdo); end
        ir_in = OP_READ;
        #1;
        n_vec += 1;
        if (tdo !== 1'b0) begin n_err++; $display("FAIL ir_comb_read got %b want 0", tdo); end
        ir_in = OP_BYP7;
        #1;
        n_vec += 2;
        if (tdo !== 1'b1) begin n_err++; $display("FAIL ir_comb_byp7 got %b want 1", tdo); end
        if (count !== v) begin n_err++; $display("FAIL bypass_count got %h want %h", count, v); end
        set_ir(4'b1010);
        capture(2);
        tdi = 1;
        v_sdr = 1;
        tick();
        v_sdr = 0;
        tdi = 0;
        update();
        n_vec += 2;
        if (count !== v) begin n_err++; $display("FAIL upper_ir_count got %h want %h", count, v); end
        if (tdo !== 1'b1) begin n_err++; $display("FAIL upper_ir_tdo got %b want 1", tdo); end
        set_ir(OP_BYP7);
        capture(1);
        n_vec += 1;
        if (count !== v) begin n_err++; $display("FAIL byp7_count got %h want %h", count, v); end
    endtask

    task automatic test_priority();
        logic [W-1:0] v1, v2, junk;
        v1 = W'($urandom);
        v2 = ~v1;
        do_load(v1);
        set_ir(OP_LOAD);
        capture(1);
        scan(v2, junk);
        v_cdr = 1;
        v_udr = 1;
        tick();
        v_cdr = 0;
        v_udr = 0;
        n_vec += 1;
        if (count !== v1) begin n_err++; $display("FAIL cdr_over_udr got %h want %h", count, v1); end
        update();
        n_vec += 1;
        if (count !== v1) begin n_err++; $display("FAIL recaptured_load got %h want %h", count, v1); end
        ir_in = OP_INC;
        v_uir = 1;
        v_cdr = 1;
        tick();
        v_uir = 0;
        v_cdr = 0;
        n_vec += 1;
        if (count !== v1) begin n_err++; $display("FAIL uir_over_cdr got %h want %h", count, v1); end
        aclr = 1;
        v_cdr = 1;
        tick();
        aclr = 0;
        v_cdr = 0;
        m_cnt = 0;
        m_ovf = 0;
        n_vec += 1;
        if (count !== 8'h00) begin n_err++; $display("FAIL aclr_over_cdr got %h want 00", count); end
    endtask

    task automatic test_reset_midscan();
        do_load(8'hFF);
        set_ir(OP_INC);
        capture(1);
        m_inc();
        set_ir(OP_LOAD);
        capture(1);
        tdi = 1;
        v_sdr = 1;
        repeat (4) tick();
        v_sdr = 0;
        tdi = 0;
        aclr = 1;
        tick();
        aclr = 0;
        m_cnt = 0;
        m_ovf = 0;
        n_vec += 3;
        if (count !== 8'h00) begin n_err++; $display("FAIL midscan_count got %h want 00", count); end
        if (ovf !== 1'b0) begin n_err++; $display("FAIL midscan_ovf got %b want 0", ovf); end
        if (tdo !== 1'b0) begin n_err++; $display("FAIL midscan_tdo got %b want 0", tdo); end
        update();
        n_vec += 1;
        if (count !== 8'h00) begin n_err++; $display("FAIL midscan_update got %h want 00", count); end
    endtask

    initial begin
        test_reset();
        test_load_read();
        test_inc_dec_random();
        test_boundary();
        test_bypass();
        test_priority();
        test_reset_midscan();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
